// File: rtl/fp_pkg.sv
// FP32 field layout, exponent bias and the partial-product record carried down the
// shared multiplier pipeline.
package fp_pkg;

    localparam int FP_W     = 32;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_LSB  = 23;
    localparam int SIGN_BIT = 31;
    localparam int EXP_BIAS = 127;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Only m[47:23] of the 48-bit mantissa product ever reaches the result.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic             zero;
        logic [24:0]      mhi;
    } fp_prod_t;

    // Exponent arithmetic wraps modulo 256, so the 9-bit intermediate is never needed.
    function automatic fp_prod_t fp_product(input fp32_t a, input fp32_t b);
        fp_prod_t p;
        p.sign = a.sign ^ b.sign;
        p.exp  = a.exp + b.exp - EXP_W'(EXP_BIAS);
        p.zero = (a.exp == '0) | (b.exp == '0);
        p.mhi  = 25'((48'({1'b1, a.frac}) * 48'({1'b1, b.frac})) >> 23);
        return p;
    endfunction

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Requester/consumer bundle of the shared FP multiplier; master is the lane/accumulator
// side, slave is the arbiter.
interface fp_mul_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int TAG_W = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;
    logic                res_valid;
    logic [31:0]         res_data;
    logic [TAG_W-1:0]    res_tag;
    logic                res_ready;
    logic                busy;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_tag, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_tag, busy
    );

endinterface

// File: rtl/fp_mul_pipe.sv
// LATENCY-stage FP32 multiplier with global enable and tag pass-through.
// FP_MUL_ZERO_DETECT_EN: a zero exponent on either operand forces a signed-zero result.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int TAG_W   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  fp32_t            in_a,
    input  fp32_t            in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int D = LATENCY - 2;

    logic             s1_valid_q, s1_valid_d;
    fp32_t            s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    fp_prod_t         prod_s1, fin_prod;
    logic             fin_valid, mid_any;
    logic [TAG_W-1:0] fin_tag;
    logic [7:0]       norm_exp;
    logic [22:0]      norm_frac;
    logic [31:0]      norm_data;

    assign prod_s1 = fp_product(s1_a_q, s1_b_q);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        if (en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d   = in_a;
                s1_b_d   = in_b;
                s1_tag_d = in_tag;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
        end
        s1_a_q   <= s1_a_d;
        s1_b_q   <= s1_b_d;
        s1_tag_q <= s1_tag_d;
    end

    if (D == 0) begin : g_no_mid
        assign fin_prod  = prod_s1;
        assign fin_valid = s1_valid_q;
        assign fin_tag   = s1_tag_q;
        assign mid_any   = 1'b0;
    end else begin : g_mid
        // Stage 0 registers the mantissa product; further stages are pure delay.
        fp_prod_t         mid_prod_q [D];
        fp_prod_t         mid_prod_d [D];
        logic [TAG_W-1:0] mid_tag_q  [D];
        logic [TAG_W-1:0] mid_tag_d  [D];
        logic [D-1:0]     mid_valid_q, mid_valid_d;

        always_comb begin
            mid_valid_d = mid_valid_q;
            mid_prod_d  = mid_prod_q;
            mid_tag_d   = mid_tag_q;
            if (en) begin
                mid_valid_d[0] = s1_valid_q;
                mid_prod_d[0]  = prod_s1;
                mid_tag_d[0]   = s1_tag_q;
                for (int k = 1; k < D; k++) begin
                    mid_valid_d[k] = mid_valid_q[k-1];
                    mid_prod_d[k]  = mid_prod_q[k-1];
                    mid_tag_d[k]   = mid_tag_q[k-1];
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                mid_valid_q <= '0;
            end else begin
                mid_valid_q <= mid_valid_d;
            end
            mid_prod_q <= mid_prod_d;
            mid_tag_q  <= mid_tag_d;
        end

        assign fin_prod  = mid_prod_q[D-1];
        assign fin_valid = mid_valid_q[D-1];
        assign fin_tag   = mid_tag_q[D-1];
        assign mid_any   = |mid_valid_q;
    end

    always_comb begin
        norm_exp  = fin_prod.exp + {7'b0, fin_prod.mhi[24]};
        norm_frac = fin_prod.mhi[24] ? fin_prod.mhi[23:1] : fin_prod.mhi[22:0];
        norm_data = {fin_prod.sign, norm_exp, norm_frac};
`ifdef FP_MUL_ZERO_DETECT_EN
        if (fin_prod.zero) begin
            norm_data = {fin_prod.sign, 31'b0};
        end
`endif
    end

`ifndef FP_MUL_ZERO_DETECT_EN
    logic unused_zero;
    assign unused_zero = fin_prod.zero;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        if (en) begin
            out_valid_d = fin_valid;
            if (fin_valid) begin
                out_data_d = norm_data;
                out_tag_d  = fin_tag;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign busy      = s1_valid_q | mid_any | out_valid_q;

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined FP32 multiplier among N_REQ lanes.
// FP_MUL_ZERO_DETECT_EN (in fp_mul_pipe) selects signed-zero output for zero exponents.
module fp_mul_arbiter
    import fp_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 3
) (
    input logic             clock,
    input logic             reset,
    fp_mul_arbiter_if.slave bus
);
    localparam int TAG_W = $clog2(N_REQ);

    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0] winner;
    logic             found;
    logic             stall;
    logic             accept;
    int               idx;
    logic [31:0]      sel_a, sel_b;

    logic             pipe_valid;
    logic [31:0]      pipe_data;
    logic [TAG_W-1:0] pipe_tag;
    logic             pipe_busy;

    assign stall = pipe_valid & ~bus.res_ready;

    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = TAG_W'(idx);
            end
        end
    end

    // Reset and a stalled output both block the grant even with a valid winner.
    assign accept        = found & ~stall & ~reset;
    assign bus.req_ready = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << winner) : '0;
    assign sel_a         = bus.req_a[32*int'(winner) +: 32];
    assign sel_b         = bus.req_b[32*int'(winner) +: 32];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (int'(winner) == N_REQ - 1) ? '0 : winner + TAG_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    fp_mul_pipe #(
        .LATENCY (LATENCY),
        .TAG_W   (TAG_W)
    ) u_pipe (
        .clock     (clock),
        .reset     (reset),
        .en        (~stall),
        .in_valid  (accept),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .in_tag    (winner),
        .out_valid (pipe_valid),
        .out_data  (pipe_data),
        .out_tag   (pipe_tag),
        .busy      (pipe_busy)
    );

    assign bus.res_valid = pipe_valid;
    assign bus.res_data  = pipe_data;
    assign bus.res_tag   = pipe_tag;
    assign bus.busy      = pipe_busy;

endmodule
